// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
//   br_type_e  : control-flow class stored in the BTB and carried to EX
//   CNT_*      : 2-bit saturating counter encodings
//   PHT_RESET  : counter value after reset (weakly not-taken)
//   cnt_next() : saturating counter step
package bp_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CNT_SNT   = 2'd0;
  localparam logic [1:0] CNT_WNT   = 2'd1;
  localparam logic [1:0] CNT_WT    = 2'd2;
  localparam logic [1:0] CNT_ST    = 2'd3;
  localparam logic [1:0] PHT_RESET = CNT_WNT;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears valid bits)
//   rd_idx, rd_tag           combinational lookup address
//   rd_hit, rd_target, rd_type  lookup result (pre-write value on same-cycle write)
//   wr_en, wr_idx, wr_tag, wr_target, wr_type  synchronous allocate/overwrite port
module bp_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int BI_W  = $clog2(ENTRIES),
  localparam int TAG_W = 30 - BI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BI_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_target,
  output br_type_e         rd_type,
  input  logic             wr_en,
  input  logic [BI_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  br_type_e         wr_type
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  br_type_e           type_q   [ENTRIES];

  // Only valid bits need clearing; payload of an invalid entry is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      type_q[wr_idx]   <= wr_type;
    end
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];
  assign rd_type   = type_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with direct-mapped BTB for the fetch stage.
// Fetch lookup is combinational from registered tables; EX update is
// sequential and the redirect decision is combinational from EX inputs.
// Optional return-address stack compiled in with `define BP_RAS_EN.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   f_valid, f_stall, f_pc           fetch request
//   f_pred_taken, f_pred_target      prediction
//   f_pht_idx, f_btb_hit             lookup details piped to EX
//   f_ghr_snap, f_ras_ptr            pre-update speculative state piped to EX
//   ex_*                             resolved branch and its piped prediction info
//   redirect_valid, redirect_pc      mispredict flush request
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_ENTRIES = 32,
  parameter int GHR_BITS    = 5,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4,
  localparam int IDX_W = $clog2(PHT_ENTRIES),
  localparam int BI_W  = $clog2(BTB_ENTRIES),
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_valid,
  input  logic                f_stall,
  input  logic [31:0]         f_pc,
  output logic                f_pred_taken,
  output logic [31:0]         f_pred_target,
  output logic [IDX_W-1:0]    f_pht_idx,
  output logic                f_btb_hit,
  output logic [GHR_BITS-1:0] f_ghr_snap,
  output logic [RP_W-1:0]     f_ras_ptr,
  input  logic                ex_update_en,
  input  logic [31:0]         ex_pc,
  input  logic [1:0]          ex_br_type,
  input  logic                ex_actual_taken,
  input  logic [31:0]         ex_actual_target,
  input  logic                ex_pred_taken,
  input  logic [31:0]         ex_pred_target,
  input  logic [IDX_W-1:0]    ex_pht_idx,
  input  logic [GHR_BITS-1:0] ex_ghr_snap,
  input  logic [RP_W-1:0]     ex_ras_ptr,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
);

  logic [1:0]          pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [31:0]         pc_plus4;
  logic [31:0]         btb_target;
  br_type_e            btb_type;
  br_type_e            ex_type;
  logic                fetch_fire;
  logic [GHR_BITS-1:0] ghr_fetch_next;
  logic [GHR_BITS-1:0] ghr_repair;

  assign pc_plus4   = f_pc + 32'd4;
  assign ex_type    = br_type_e'(ex_br_type);
  assign f_ghr_snap = ghr;
  assign f_pht_idx  = f_pc[IDX_W+1:2] ^ IDX_W'(ghr);

  bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (f_pc[BI_W+1:2]),
    .rd_tag    (f_pc[31:BI_W+2]),
    .rd_hit    (f_btb_hit),
    .rd_target (btb_target),
    .rd_type   (btb_type),
    .wr_en     (ex_update_en && ex_actual_taken),
    .wr_idx    (ex_pc[BI_W+1:2]),
    .wr_tag    (ex_pc[31:BI_W+2]),
    .wr_target (ex_actual_target),
    .wr_type   (ex_type)
  );

  assign fetch_fire = f_valid && !f_stall && f_btb_hit;

`ifdef BP_RAS_EN
  localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);

  logic [31:0]     ras_stack [RAS_DEPTH];
  logic [RP_W-1:0] ras_ptr;
  logic [31:0]     ras_top;

  assign ras_top   = ras_stack[ras_ptr - RP_ONE];
  assign f_ras_ptr = ras_ptr;

  // Circular stack: overflow overwrites the oldest slot, underflow just wraps.
  // A wrong-path push/pop in the redirect cycle is dropped entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr <= '0;
    end else if (redirect_valid) begin
      if (ex_type == BR_CALL)     ras_ptr <= ex_ras_ptr + RP_ONE;
      else if (ex_type == BR_RET) ras_ptr <= ex_ras_ptr - RP_ONE;
      else                        ras_ptr <= ex_ras_ptr;
    end else if (fetch_fire) begin
      if (btb_type == BR_CALL) begin
        ras_stack[ras_ptr] <= pc_plus4;
        ras_ptr            <= ras_ptr + RP_ONE;
      end else if (btb_type == BR_RET) begin
        ras_ptr <= ras_ptr - RP_ONE;
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^ex_ras_ptr;
  assign f_ras_ptr  = '0;
`endif

  always_comb begin
    f_pred_taken  = 1'b0;
    f_pred_target = pc_plus4;
    if (f_btb_hit) begin
      f_pred_taken = (btb_type == BR_COND) ? pht[f_pht_idx][1] : 1'b1;
    end
    if (f_pred_taken) begin
      f_pred_target = btb_target;
`ifdef BP_RAS_EN
      if (btb_type == BR_RET) f_pred_target = ras_top;
`endif
    end
  end

  always_comb begin
    redirect_valid = ex_update_en &&
                     ((ex_pred_taken != ex_actual_taken) ||
                      (ex_actual_taken && (ex_pred_target != ex_actual_target)));
    redirect_pc    = ex_actual_taken ? ex_actual_target : ex_pc + 32'd4;
  end

  // Truncating casts drop the oldest history bit on a shift.
  assign ghr_fetch_next = GHR_BITS'({ghr, f_pred_taken});
  assign ghr_repair     = (ex_type == BR_COND) ? GHR_BITS'({ex_ghr_snap, ex_actual_taken})
                                               : ex_ghr_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (redirect_valid) begin
      ghr <= ghr_repair;
    end else if (fetch_fire && (btb_type == BR_COND)) begin
      ghr <= ghr_fetch_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_RESET;
    end else if (ex_update_en && (ex_type == BR_COND)) begin
      pht[ex_pht_idx] <= cnt_next(pht[ex_pht_idx], ex_actual_taken);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int IDX_W = 5;
  localparam int GHR_BITS = 5;
  localparam int RP_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                f_valid;
  logic                f_stall;
  logic [31:0]         f_pc;
  logic                f_pred_taken;
  logic [31:0]         f_pred_target;
  logic [IDX_W-1:0]    f_pht_idx;
  logic                f_btb_hit;
  logic [GHR_BITS-1:0] f_ghr_snap;
  logic [RP_W-1:0]     f_ras_ptr;
  logic                ex_update_en;
  logic [31:0]         ex_pc;
  logic [1:0]          ex_br_type;
  logic                ex_actual_taken;
  logic [31:0]         ex_actual_target;
  logic                ex_pred_taken;
  logic [31:0]         ex_pred_target;
  logic [IDX_W-1:0]    ex_pht_idx;
  logic [GHR_BITS-1:0] ex_ghr_snap;
  logic [RP_W-1:0]     ex_ras_ptr;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;

  int total = 0;
  int bad = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_stall(f_stall), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .f_pht_idx(f_pht_idx), .f_btb_hit(f_btb_hit),
    .f_ghr_snap(f_ghr_snap), .f_ras_ptr(f_ras_ptr),
    .ex_update_en(ex_update_en), .ex_pc(ex_pc), .ex_br_type(ex_br_type),
    .ex_actual_taken(ex_actual_taken), .ex_actual_target(ex_actual_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_pht_idx(ex_pht_idx), .ex_ghr_snap(ex_ghr_snap), .ex_ras_ptr(ex_ras_ptr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ex_upd(input logic [31:0] pc, input br_type_e t, input logic act_t,
                        input logic [31:0] act_tgt, input logic pred_t,
                        input logic [31:0] pred_tgt, input logic [IDX_W-1:0] idx,
                        input logic [GHR_BITS-1:0] snap, input logic [RP_W-1:0] rp);
    ex_update_en     = 1'b1;
    ex_pc            = pc;
    ex_br_type       = t;
    ex_actual_taken  = act_t;
    ex_actual_target = act_tgt;
    ex_pred_taken    = pred_t;
    ex_pred_target   = pred_tgt;
    ex_pht_idx       = idx;
    ex_ghr_snap      = snap;
    ex_ras_ptr       = rp;
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b0; f_stall = 1'b0; f_pc = '0;
    ex_update_en = 1'b0; ex_pc = '0; ex_br_type = '0; ex_actual_taken = 1'b0;
    ex_actual_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    ex_pht_idx = '0; ex_ghr_snap = '0; ex_ras_ptr = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Cleared state
    f_valid = 1'b1; f_pc = 32'h100; #1;
    check("reset_taken", f_pred_taken, 0);
    check("reset_target", f_pred_target, 32'h104);
    check("reset_hit", f_btb_hit, 0);
    check("reset_ghr", f_ghr_snap, 0);
    check("reset_redirect", redirect_valid, 0);
    check("reset_ras_ptr", f_ras_ptr, 0);

    // Cond branch 0x200 -> 0x180, two taken updates, fetch held
    f_stall = 1'b1; f_pc = 32'h200;
    ex_upd(32'h200, BR_COND, 1, 32'h180, 1, 32'h180, 0, 0, 0); #1;
    check("no_bypass_hit", f_btb_hit, 0);
    check("match_no_redirect", redirect_valid, 0);
    tick();                                   // counter 2
    check("cond_hit", f_btb_hit, 1);
    check("cond_taken_cnt2", f_pred_taken, 1);
    check("cond_target", f_pred_target, 32'h180);
    check("cond_idx", f_pht_idx, 0);
    tick();                                   // counter 3
    tick(); tick();                           // saturated at 3
    ex_upd(32'h200, BR_COND, 0, 32'h180, 1, 32'h180, 0, 0, 0); #1;
    check("nt_redirect", redirect_valid, 1);
    check("nt_redirect_pc", redirect_pc, 32'h204);
    tick();                                   // 2 if saturated at 3
    check("sat3_then_nt", f_pred_taken, 1);
    tick();                                   // 1
    check("cnt1_not_taken", f_pred_taken, 0);
    tick(); tick();                           // 0, stays 0
    check("sat0_not_taken", f_pred_taken, 0);
    check("nt_keeps_btb", f_btb_hit, 1);
    check("nt_repair_ghr", f_ghr_snap, 0);
    ex_upd(32'h200, BR_COND, 1, 32'h180, 1, 32'h180, 0, 0, 0);
    tick();                                   // 1
    check("from0_to1", f_pred_taken, 0);
    tick();                                   // 2
    check("from1_to2", f_pred_taken, 1);
    ex_update_en = 1'b0;

    // Non-cond repair loads snapshot directly
    ex_upd(32'h604, BR_JUMP, 1, 32'h700, 0, 32'h608, 0, 5'b00011, 0); #1;
    check("jump_redirect", redirect_valid, 1);
    check("jump_redirect_pc", redirect_pc, 32'h700);
    tick(); ex_update_en = 1'b0; #1;
    check("jump_repair_ghr", f_ghr_snap, 5'b00011);
    check("ghr_idx", f_pht_idx, 5'd3);
    check("idx3_not_taken", f_pred_taken, 0);
    check("idx3_target", f_pred_target, 32'h204);

    // Speculative shift of a not-taken prediction
    f_stall = 1'b0; tick(); f_stall = 1'b1; #1;
    check("spec_shift", f_ghr_snap, 5'b00110);

    // Repair beats same-cycle fetch shift
    f_stall = 1'b0;
    ex_upd(32'h388, BR_COND, 1, 32'h400, 0, 32'h38C, 5'd10, 5'b01010, 0); #1;
    check("repair_redirect", redirect_valid, 1);
    check("repair_redirect_pc", redirect_pc, 32'h400);
    tick(); ex_update_en = 1'b0; f_stall = 1'b1; #1;
    check("repair_ghr", f_ghr_snap, 5'b10101);

    // Jump at 0x300: install, then wrong-target resolution
    ex_upd(32'h300, BR_JUMP, 1, 32'h500, 1, 32'h500, 0, 5'b10101, 0);
    tick(); ex_update_en = 1'b0; f_pc = 32'h300; #1;
    check("jump_hit", f_btb_hit, 1);
    check("jump_taken", f_pred_taken, 1);
    check("jump_target", f_pred_target, 32'h500);
    f_pc = 32'h200; #1;
    check("evicted_miss", f_btb_hit, 0);
    f_pc = 32'h300;
    ex_upd(32'h300, BR_JUMP, 1, 32'h540, 1, 32'h500, 0, 5'b10101, 0); #1;
    check("tgt_redirect", redirect_valid, 1);
    check("tgt_redirect_pc", redirect_pc, 32'h540);
    tick(); ex_update_en = 1'b0; #1;
    check("jump_new_target", f_pred_target, 32'h540);
    check("jump_ghr_kept", f_ghr_snap, 5'b10101);

`ifndef BP_RAS_EN
    ex_upd(32'h70C, BR_RET, 1, 32'h888, 1, 32'h888, 0, 5'b10101, 0);
    tick(); ex_update_en = 1'b0; f_pc = 32'h70C; #1;
    check("ret_taken", f_pred_taken, 1);
    check("ret_btb_target", f_pred_target, 32'h888);
    f_stall = 1'b0; tick(); f_stall = 1'b1; #1;
    check("ras_ptr_tied", f_ras_ptr, 0);
`else
    begin
      logic [31:0] calls [4];
      calls = '{32'h10, 32'h20, 32'h30, 32'h40};
      for (int i = 0; i < 4; i++) begin
        ex_upd(calls[i], BR_CALL, 1, 32'h900, 1, 32'h900, 0, 5'b10101, 0);
        tick();
      end
      ex_update_en = 1'b0;
      f_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
        f_pc = calls[i];
        tick();
      end
      f_stall = 1'b1; #1;
      check("ras_wrap_ptr", f_ras_ptr, 0);
    end
    ex_upd(32'h50, BR_CALL, 1, 32'h900, 1, 32'h900, 0, 5'b10101, 0); tick();
    ex_upd(32'h68, BR_RET, 1, 32'h999, 1, 32'h999, 0, 5'b10101, 0); tick();
    ex_update_en = 1'b0;
    f_pc = 32'h50; f_stall = 1'b0; tick(); f_stall = 1'b1; #1;
    check("ras_ptr_after5", f_ras_ptr, 1);
    f_pc = 32'h68; #1;
    check("ras_ret_taken", f_pred_taken, 1);
    check("ras_ret_target", f_pred_target, 32'h54);
    f_stall = 1'b0; tick(); f_stall = 1'b1; #1;
    check("ras_pop_ptr", f_ras_ptr, 0);
    check("ras_next_top", f_pred_target, 32'h44);
    ex_upd(32'h68, BR_RET, 1, 32'h123, 1, 32'h44, 0, 5'b10101, 2'd2);
    tick(); ex_update_en = 1'b0; #1;
    check("ras_repair_ptr", f_ras_ptr, 1);
    check("ras_repair_top", f_pred_target, 32'h54);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
